// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: word width, NOP encoding, default reset PC,
// instruction-fetch FSM state encoding and a PC increment helper.
package cpu_defs_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Encoding is shared with debug/trace tooling, so it is fixed explicitly.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } if_state_t;

    // PC increment; natural wrap modulo 2^WORD_W.
    function automatic logic [WORD_W-1:0] pc_add(input logic [WORD_W-1:0] pc,
                                                 input int unsigned       step);
        return pc + WORD_W'(step);
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// Pipeline register between two stages (used here as IF/ID).
// Priority: rst > flush (bubble) > freeze (hold) > load (capture);
// with none asserted the register takes a bubble.
module if_id_reg
    import cpu_defs_pkg::*;
#(
    parameter int unsigned W = WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         freeze,
    input  logic         flush,
    input  logic [W-1:0] pc_in,
    input  logic [W-1:0] instr_in,
    output logic [W-1:0] pc,
    output logic [W-1:0] instr,
    output logic         valid
);

    // Pipeline register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            instr <= W'(NOP_INSTR);
            valid <= 1'b0;
        end else if (flush) begin
            pc    <= '0;
            instr <= W'(NOP_INSTR);
            valid <= 1'b0;
        end else if (freeze) begin
            pc    <= pc;
            instr <= instr;
            valid <= valid;
        end else if (load) begin
            pc    <= pc_in;
            instr <= instr_in;
            valid <= 1'b1;
        end else begin
            pc    <= '0;
            instr <= W'(NOP_INSTR);
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/ack handshake to a
// variable-latency instruction memory, buffers one word returned while
// decode is frozen, and redirects on taken branches.
// Optional macro IF_PERF_CNT_EN adds the fetch_stall_cycles counter port.
module if_stage
    import cpu_defs_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [WORD_W-1:0] PC_out,
    output logic [WORD_W-1:0] Instruction,
    output logic              inst_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0] fetch_stall_cycles
`endif
);

    if_state_t         state_q, state_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [WORD_W-1:0] hold_pc_q, hold_pc_d;
    logic [WORD_W-1:0] hold_instr_q, hold_instr_d;

    logic [WORD_W-1:0] pc_plus;
    logic              reg_load;
    logic              reg_freeze;
    logic              reg_flush;
    logic [WORD_W-1:0] reg_pc_in;
    logic [WORD_W-1:0] reg_instr_in;

    assign pc_plus   = pc_add(fetch_pc_q, PC_STEP);
    // Address comes straight from a register so it is stable until ack.
    assign imem_addr = fetch_pc_q;

    // State and fetch bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= '0;
            hold_pc_q     <= '0;
            hold_instr_q  <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
        end
    end

    // Next-state logic, memory request and IF/ID register controls.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        reg_load      = 1'b0;
        reg_freeze    = 1'b0;
        reg_flush     = 1'b0;
        reg_pc_in     = pc_plus;
        reg_instr_in  = imem_rdata;
        imem_req      = 1'b0;

        unique case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    reg_flush = 1'b1;
                    if (imem_ack) begin
                        fetch_pc_d = branch_addr;
                    end else begin
                        // Outstanding request must complete on its old address.
                        redirect_pc_d = branch_addr;
                        state_d       = DRAIN;
                    end
                end else if (imem_ack) begin
                    fetch_pc_d = pc_plus;
                    if (freeze) begin
                        reg_freeze   = 1'b1;
                        hold_pc_d    = pc_plus;
                        hold_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end else begin
                        reg_load = 1'b1;
                    end
                end else begin
                    // Not frozen and no data: register takes a bubble.
                    reg_freeze = freeze;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                reg_flush = 1'b1;
                if (imem_ack) begin
                    // A branch arriving with the ack is the newest target.
                    fetch_pc_d = branch_taken ? branch_addr : redirect_pc_q;
                    state_d    = FETCH;
                end else if (branch_taken) begin
                    redirect_pc_d = branch_addr;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    reg_flush  = 1'b1;
                    fetch_pc_d = branch_addr;
                    state_d    = FETCH;
                end else if (!freeze) begin
                    reg_load     = 1'b1;
                    reg_pc_in    = hold_pc_q;
                    reg_instr_in = hold_instr_q;
                    state_d      = FETCH;
                end else begin
                    reg_freeze = 1'b1;
                end
            end
            default: begin
                reg_flush = 1'b1;
                state_d   = FETCH;
            end
        endcase

        if (rst) begin
            imem_req = 1'b0;
        end
    end

    if_id_reg #(
        .W (WORD_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (reg_load),
        .freeze   (reg_freeze),
        .flush    (reg_flush),
        .pc_in    (reg_pc_in),
        .instr_in (reg_instr_in),
        .pc       (PC_out),
        .instr    (Instruction),
        .valid    (inst_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [WORD_W-1:0] stall_cnt_q;

    // Saturating count of cycles spent waiting on memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (imem_req && !imem_ack && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign fetch_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage. Memory returns addr ^ 0xDEAD_0000.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] PC_out;
    logic [31:0] Instruction;
    logic        inst_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_stall_cycles;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .PC_out       (PC_out),
        .Instruction  (Instruction),
        .inst_valid   (inst_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_stall_cycles (fetch_stall_cycles)
`endif
    );

    assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; imem_ack = 1'b1;
        #1;
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req_pre: got %b want 0", imem_req); else pass_cnt++;
        tick();
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", imem_addr); else pass_cnt++;
        total_cnt++; if (PC_out !== 32'h0) $display("FAIL rst_pc: got %h want 0", PC_out); else pass_cnt++;
        total_cnt++; if (Instruction !== 32'h0) $display("FAIL rst_instr: got %h want 0", Instruction); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", inst_valid); else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b1;
        do_reset();
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL zw_req0: got %b want 1", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL zw_addr0: got %h want 0", imem_addr); else pass_cnt++;
        tick();
        total_cnt++; if (Instruction !== 32'hDEAD_0000) $display("FAIL zw_instr0: got %h want dead0000", Instruction); else pass_cnt++;
        total_cnt++; if (PC_out !== 32'h4) $display("FAIL zw_pc0: got %h want 4", PC_out); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b1) $display("FAIL zw_valid0: got %b want 1", inst_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h4) $display("FAIL zw_addr1: got %h want 4", imem_addr); else pass_cnt++;
        tick();
        total_cnt++; if (Instruction !== 32'hDEAD_0004) $display("FAIL zw_instr1: got %h want dead0004", Instruction); else pass_cnt++;
        total_cnt++; if (PC_out !== 32'h8) $display("FAIL zw_pc1: got %h want 8", PC_out); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h8) $display("FAIL zw_addr2: got %h want 8", imem_addr); else pass_cnt++;
        tick();
        total_cnt++; if (Instruction !== 32'hDEAD_0008) $display("FAIL zw_instr2: got %h want dead0008", Instruction); else pass_cnt++;
        total_cnt++; if (PC_out !== 32'hC) $display("FAIL zw_pc2: got %h want c", PC_out); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b1) $display("FAIL zw_valid2: got %b want 1", inst_valid); else pass_cnt++;
    endtask

    task automatic test_latency();
        freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        do_reset();
        tick();
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL lat_valid0: got %b want 0", inst_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL lat_addr_held: got %h want 0", imem_addr); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL lat_req_held: got %b want 1", imem_req); else pass_cnt++;
        imem_ack = 1'b1;
        tick();
        total_cnt++; if (inst_valid !== 1'b1) $display("FAIL lat_valid1: got %b want 1", inst_valid); else pass_cnt++;
        total_cnt++; if (Instruction !== 32'hDEAD_0000) $display("FAIL lat_instr1: got %h want dead0000", Instruction); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h4) $display("FAIL lat_addr1: got %h want 4", imem_addr); else pass_cnt++;
        imem_ack = 1'b0;
        tick();
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL lat_valid2: got %b want 0", inst_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h4) $display("FAIL lat_addr2: got %h want 4", imem_addr); else pass_cnt++;
        imem_ack = 1'b1;
        tick();
        total_cnt++; if (inst_valid !== 1'b1) $display("FAIL lat_valid3: got %b want 1", inst_valid); else pass_cnt++;
        total_cnt++; if (PC_out !== 32'h8) $display("FAIL lat_pc3: got %h want 8", PC_out); else pass_cnt++;
    endtask

    task automatic test_freeze_hold();
        freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b1;
        do_reset();
        tick();
        tick();
        freeze = 1'b1;  // ack of address 8 arrives while frozen
        tick();
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (imem_req !== 1'b0) $display("FAIL frz_req%0d: got %b want 0", i, imem_req); else pass_cnt++;
            total_cnt++; if (Instruction !== 32'hDEAD_0004) $display("FAIL frz_instr%0d: got %h want dead0004", i, Instruction); else pass_cnt++;
            total_cnt++; if (PC_out !== 32'h8) $display("FAIL frz_pc%0d: got %h want 8", i, PC_out); else pass_cnt++;
            if (i < 2) tick();
        end
        freeze = 1'b0; imem_ack = 1'b0;
        tick();
        total_cnt++; if (Instruction !== 32'hDEAD_0008) $display("FAIL frz_rel_instr: got %h want dead0008", Instruction); else pass_cnt++;
        total_cnt++; if (PC_out !== 32'hC) $display("FAIL frz_rel_pc: got %h want c", PC_out); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b1) $display("FAIL frz_rel_valid: got %b want 1", inst_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'hC) $display("FAIL frz_rel_addr: got %h want c", imem_addr); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL frz_rel_req: got %b want 1", imem_req); else pass_cnt++;
    endtask

    task automatic test_branch_drain();
        freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        imem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h40;
        tick();
        branch_taken = 1'b0;
        total_cnt++; if (imem_addr !== 32'h10) $display("FAIL drn_addr0: got %h want 10", imem_addr); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL drn_valid0: got %b want 0", inst_valid); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL drn_req0: got %b want 1", imem_req); else pass_cnt++;
        tick();
        total_cnt++; if (imem_addr !== 32'h10) $display("FAIL drn_addr1: got %h want 10", imem_addr); else pass_cnt++;
        imem_ack = 1'b1;
        tick();
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL drn_drop_valid: got %b want 0", inst_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h40) $display("FAIL drn_redirect: got %h want 40", imem_addr); else pass_cnt++;
        tick();
        total_cnt++; if (Instruction !== 32'hDEAD_0040) $display("FAIL drn_instr: got %h want dead0040", Instruction); else pass_cnt++;
        total_cnt++; if (PC_out !== 32'h44) $display("FAIL drn_pc: got %h want 44", PC_out); else pass_cnt++;
    endtask

    task automatic test_branch_hold();
        freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b1;
        do_reset();
        branch_taken = 1'b1; branch_addr = 32'h20;  // same-cycle ack redirect
        tick();
        total_cnt++; if (imem_addr !== 32'h20) $display("FAIL bh_addr20: got %h want 20", imem_addr); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL bh_valid0: got %b want 0", inst_valid); else pass_cnt++;
        branch_taken = 1'b0; freeze = 1'b1;
        tick();
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL bh_hold_req: got %b want 0", imem_req); else pass_cnt++;
        branch_taken = 1'b1; branch_addr = 32'h80;
        tick();
        branch_taken = 1'b0; freeze = 1'b0;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL bh_valid1: got %b want 0", inst_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h80) $display("FAIL bh_addr80: got %h want 80", imem_addr); else pass_cnt++;
        tick();
        total_cnt++; if (Instruction !== 32'hDEAD_0080) $display("FAIL bh_instr: got %h want dead0080", Instruction); else pass_cnt++;
        total_cnt++; if (PC_out !== 32'h84) $display("FAIL bh_pc: got %h want 84", PC_out); else pass_cnt++;
    endtask

    task automatic test_wrap_and_reset();
        freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b1;
        do_reset();
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        total_cnt++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr_top: got %h want fffffffc", imem_addr); else pass_cnt++;
        tick();
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr: got %h want 0", imem_addr); else pass_cnt++;
        total_cnt++; if (PC_out !== 32'h0) $display("FAIL wrap_pc: got %h want 0", PC_out); else pass_cnt++;
        total_cnt++; if (Instruction !== 32'h2152_FFFC) $display("FAIL wrap_instr: got %h want 2152fffc", Instruction); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b1) $display("FAIL wrap_valid: got %b want 1", inst_valid); else pass_cnt++;
        tick();
        imem_ack = 1'b0;
        tick();
        total_cnt++; if (imem_addr !== 32'h4) $display("FAIL mid_wait_addr: got %h want 4", imem_addr); else pass_cnt++;
        rst = 1'b1; imem_ack = 1'b1;
        #1;
        total_cnt++; if (imem_req !== 1'b0) $display("FAIL mid_rst_req: got %b want 0", imem_req); else pass_cnt++;
        tick();
        rst = 1'b0; imem_ack = 1'b0;
        #1;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL mid_rst_addr: got %h want 0", imem_addr); else pass_cnt++;
        total_cnt++; if (PC_out !== 32'h0) $display("FAIL mid_rst_pc: got %h want 0", PC_out); else pass_cnt++;
        total_cnt++; if (Instruction !== 32'h0) $display("FAIL mid_rst_instr: got %h want 0", Instruction); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", inst_valid); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL mid_rst_req_rel: got %b want 1", imem_req); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_freeze_hold();
        test_branch_drain();
        test_branch_hold();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
